// File: rtl/rfft_pkg.sv
// Shared constants, FSM encoding and fixed datapath selects for the real-FFT sequencer.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package rfft_pkg;

    localparam int DATA_BIT   = 16;
    localparam int ADDR_BIT   = 6;
    localparam int N          = 256;
    localparam int MEM_HEIGHT = N / 4;
    localparam int NUM_STAGES = 8;
    localparam int PIPE_LAT   = 2;

    // Passes below this index run with the twiddle multiplier bypassed.
    localparam int BYPASS_STAGES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READ,
        ST_WAIT,
        ST_FIN
    } state_t;

    // Datapath mux selects held while a compute pass is running.
    localparam logic       M0_CMP  = 1'b1;
    localparam logic       M11_CMP = 1'b0;
    localparam logic [1:0] M12_CMP = 2'd1;
    localparam logic [1:0] M13_CMP = 2'd1;
    localparam logic       M14_CMP = 1'b1;
    localparam logic       M21_CMP = 1'b0;
    localparam logic       M22_CMP = 1'b0;
    localparam logic       M23_CMP = 1'b1;
    localparam logic       M24_CMP = 1'b1;

    // Read-address offset of a pass: passes 0 and 1 start at row 0, later
    // passes start at the top 1/2, 3/4, 7/8 ... of the bank.
    function automatic int stage_off(input int stage, input int mem_height);
        if (stage < 2) begin
            return 0;
        end
        return mem_height - (mem_height >> (stage - 1));
    endfunction

endpackage

// File: rtl/rfft_seq_if.sv
// Input row stream: one row of four samples per beat, valid/ready handshake.
// Latency: n/a (wiring only).
// Backpressure: producer holds s_valid/s_data until s_ready is seen high.
interface rfft_seq_if #(
    parameter int DATA_BIT = rfft_pkg::DATA_BIT
);
    logic                  s_valid;
    logic                  s_ready;
    logic [4*DATA_BIT-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/rfft_delay.sv
// Fixed-depth shift line carrying a valid flag and payload (write-back strobe and address).
// Latency: DEPTH cycles from src to dst.
// Backpressure: none; every entry advances each cycle, synchronous reset drops all entries.
module rfft_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_vld,
    input  logic [WIDTH-1:0] src_dat,
    output logic             dst_vld,
    output logic [WIDTH-1:0] dst_dat
);

    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] dat_q [DEPTH];

    // Shift one position per cycle; reset empties the line so no stale write survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= src_vld;
            dat_q[0] <= src_dat;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign dst_vld = vld_q[DEPTH-1];
    assign dst_dat = dat_q[DEPTH-1];

endmodule

// File: rtl/rfft_seq.sv
// Sequencer for an in-place 4-bank real FFT: loads rows, then runs NUM_STAGES read/write-back passes.
// Latency: done pulses MEM_HEIGHT + NUM_STAGES*(MEM_HEIGHT+PIPE_LAT) + 1 cycles after the first row (no stalls).
// Backpressure: s_ready high only in LOAD; a low s_valid stalls loading indefinitely, compute never stalls.
module rfft_seq #(
    parameter int DATA_BIT   = rfft_pkg::DATA_BIT,
    parameter int ADDR_BIT   = rfft_pkg::ADDR_BIT,
    parameter int N          = rfft_pkg::N,
    parameter int MEM_HEIGHT = N / 4,
    parameter int NUM_STAGES = rfft_pkg::NUM_STAGES,
    parameter int PIPE_LAT   = rfft_pkg::PIPE_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    rfft_seq_if.slave             s,
    output logic [DATA_BIT-1:0]   in0,
    output logic [DATA_BIT-1:0]   in1,
    output logic [DATA_BIT-1:0]   in2,
    output logic [DATA_BIT-1:0]   in3,
    output logic                  en,
    output logic                  re,
    output logic                  we,
    output logic [4*ADDR_BIT-1:0] addr_read,
    output logic [4*ADDR_BIT-1:0] addr_write,
    output logic                  m0,
    output logic                  m11,
    output logic [1:0]            m12,
    output logic [1:0]            m13,
    output logic                  m14,
    output logic                  m21,
    output logic                  m22,
    output logic                  m23,
    output logic                  m24,
    output logic                  bypass_en,
    output logic [ADDR_BIT-1:0]   tw_addr,
    output logic [3:0]            stage,
    output logic                  busy,
    output logic                  done
);
    import rfft_pkg::*;

    localparam int WCNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [ADDR_BIT-1:0] CNT_LAST   = ADDR_BIT'(MEM_HEIGHT - 1);
    localparam logic [WCNT_W-1:0]   WAIT_LAST  = WCNT_W'(PIPE_LAT - 1);
    localparam logic [3:0]          STAGE_LAST = 4'(NUM_STAGES - 1);

    state_t              state;
    logic [ADDR_BIT-1:0] cnt;
    logic [WCNT_W-1:0]   wcnt;
    logic                s_ready_q;
    logic                load_fire;
    logic                rd_fire;
    logic [ADDR_BIT-1:0] rd_addr;
    logic                wb_vld;
    logic [ADDR_BIT-1:0] wb_addr;

    assign s.s_ready = s_ready_q;
    assign load_fire = (state == ST_LOAD) && s.s_valid && s_ready_q;
    assign rd_fire   = (state == ST_READ);
    // Width truncation gives the wrap modulo the bank height.
    assign rd_addr   = ADDR_BIT'(stage_off(int'(stage), MEM_HEIGHT) + int'(cnt));

    // Each issued read index re-emerges PIPE_LAT cycles later as the write-back row.
    rfft_delay #(
        .DEPTH (PIPE_LAT),
        .WIDTH (ADDR_BIT)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .src_vld (rd_fire),
        .src_dat (cnt),
        .dst_vld (wb_vld),
        .dst_dat (wb_addr)
    );

    // Control FSM with all memory/datapath controls registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            wcnt       <= '0;
            stage      <= '0;
            s_ready_q  <= 1'b0;
            en         <= 1'b0;
            re         <= 1'b0;
            we         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            addr_read  <= '0;
            addr_write <= '0;
            in0        <= '0;
            in1        <= '0;
            in2        <= '0;
            in3        <= '0;
            m0         <= 1'b0;
            m11        <= 1'b0;
            m12        <= 2'd0;
            m13        <= 2'd0;
            m14        <= 1'b0;
            m21        <= 1'b0;
            m22        <= 1'b0;
            m23        <= 1'b0;
            m24        <= 1'b0;
            bypass_en  <= 1'b0;
            tw_addr    <= '0;
        end else begin
            re   <= 1'b0;
            done <= 1'b0;
            we   <= wb_vld;
            en   <= wb_vld;
            if (wb_vld) begin
                addr_write <= {4{wb_addr}};
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_LOAD;
                        cnt       <= '0;
                        s_ready_q <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (load_fire) begin
                        we         <= 1'b1;
                        en         <= 1'b1;
                        in0        <= s.s_data[0*DATA_BIT +: DATA_BIT];
                        in1        <= s.s_data[1*DATA_BIT +: DATA_BIT];
                        in2        <= s.s_data[2*DATA_BIT +: DATA_BIT];
                        in3        <= s.s_data[3*DATA_BIT +: DATA_BIT];
                        addr_write <= {4{cnt}};
                        if (cnt == CNT_LAST) begin
                            state     <= ST_READ;
                            cnt       <= '0;
                            stage     <= '0;
                            s_ready_q <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    en        <= 1'b1;
                    re        <= 1'b1;
                    addr_read <= {4{rd_addr}};
                    tw_addr   <= cnt;
                    m0        <= M0_CMP;
                    m11       <= M11_CMP;
                    m12       <= M12_CMP;
                    m13       <= M13_CMP;
                    m14       <= M14_CMP;
                    m21       <= M21_CMP;
                    m22       <= M22_CMP;
                    m23       <= M23_CMP;
                    m24       <= M24_CMP;
                    bypass_en <= (stage < 4'(BYPASS_STAGES));
                    if (cnt == CNT_LAST) begin
                        state <= ST_WAIT;
                        cnt   <= '0;
                        wcnt  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (wcnt == WAIT_LAST) begin
                        wcnt <= '0;
                        if (stage == STAGE_LAST) begin
                            state     <= ST_FIN;
                            m0        <= 1'b0;
                            m11       <= 1'b0;
                            m12       <= 2'd0;
                            m13       <= 2'd0;
                            m14       <= 1'b0;
                            m21       <= 1'b0;
                            m22       <= 1'b0;
                            m23       <= 1'b0;
                            m24       <= 1'b0;
                            bypass_en <= 1'b0;
                        end else begin
                            stage <= stage + 4'd1;
                            state <= ST_READ;
                        end
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    stage <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rfft_seq.sv
module tb_rfft_seq;

    localparam int DB = rfft_pkg::DATA_BIT;
    localparam int MH = rfft_pkg::MEM_HEIGHT;
    localparam int NS = rfft_pkg::NUM_STAGES;
    localparam int PL = rfft_pkg::PIPE_LAT;
    localparam int DONE_AT = MH + NS * (MH + PL) + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [DB-1:0] in0, in1, in2, in3;
    logic        en, re, we;
    logic [23:0] addr_read, addr_write;
    logic        m0, m11, m14, m21, m22, m23, m24;
    logic [1:0]  m12, m13;
    logic        bypass_en;
    logic [5:0]  tw_addr;
    logic [3:0]  stage;
    logic        busy, done;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    rfft_seq_if #(.DATA_BIT(DB)) sif ();

    rfft_seq u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s          (sif),
        .in0        (in0),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .en         (en),
        .re         (re),
        .we         (we),
        .addr_read  (addr_read),
        .addr_write (addr_write),
        .m0         (m0),
        .m11        (m11),
        .m12        (m12),
        .m13        (m13),
        .m14        (m14),
        .m21        (m21),
        .m22        (m22),
        .m23        (m23),
        .m24        (m24),
        .bypass_en  (bypass_en),
        .tw_addr    (tw_addr),
        .stage      (stage),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    wire any_out = |{in0, in1, in2, in3, en, re, we, busy, done, sif.s_ready,
                     addr_read, addr_write, m0, m11, m12, m13, m14, m21, m22,
                     m23, m24, bypass_en, tw_addr, stage};

    // Start row of a pass, from the rule: 0 for passes 0/1, else MH - MH/2^(s-1).
    function automatic int exp_off(input int s);
        if (s < 2) return 0;
        return MH - MH / (2 ** (s - 1));
    endfunction

    // Loads MH rows, optionally stalling before one row; checks every bank write.
    task automatic do_load(input bit pat, input int stall_row, input int stall_len, output int t_acc);
        logic [DB-1:0] lane [4][MH];
        int q[$];
        int row = 0;
        int st  = 0;
        int wr  = 0;
        int r;
        t_acc = 0;
        for (int i = 0; i < MH; i++)
            for (int k = 0; k < 4; k++)
                lane[k][i] = pat ? DB'(k * MH + i) : DB'($urandom);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        vectors++;
        if (sif.s_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_entry s_ready=%b busy=%b, want 1 1", sif.s_ready, busy);
        end
        for (int k = 0; k < 400 && wr < MH; k++) begin
            if (row < MH && !(row == stall_row && st < stall_len)) begin
                sif.s_valid = 1'b1;
                sif.s_data  = {lane[3][row], lane[2][row], lane[1][row], lane[0][row]};
                if (row == 0) t_acc = cyc;
                q.push_back(row);
                row++;
            end else begin
                sif.s_valid = 1'b0;
                if (row == stall_row) st++;
            end
            @(negedge clk);
            vectors++;
            if (sif.s_ready !== 1'(row < MH)) begin
                errors++;
                $display("FAIL load_ready row=%0d got %b want %b", row, sif.s_ready, row < MH);
            end
            vectors++;
            if (we !== 1'(q.size() > 0)) begin
                errors++;
                $display("FAIL load_we row=%0d got %b want %b", row, we, q.size() > 0);
            end
            if (q.size() > 0) begin
                r = q.pop_front();
                wr++;
                vectors++;
                if (addr_write !== {4{6'(r)}} ||
                    {in3, in2, in1, in0} !== {lane[3][r], lane[2][r], lane[1][r], lane[0][r]}) begin
                    errors++;
                    $display("FAIL load_data row=%0d got addr=%h data=%h want addr=%0d data=%h",
                             r, addr_write, {in3, in2, in1, in0}, r,
                             {lane[3][r], lane[2][r], lane[1][r], lane[0][r]});
                end
            end
        end
        sif.s_valid = 1'b0;
        vectors++;
        if (wr !== MH) begin
            errors++;
            $display("FAIL load_count got %0d want %0d", wr, MH);
        end
        vectors++;
        if (stage !== 4'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_exit stage=%0d busy=%b want 0 1", stage, busy);
        end
    endtask

    // Follows the compute passes; stops mid-pass stop_stage or after done when stop_stage >= NS.
    task automatic run_compute(input int t_acc, input int stalls, input int stop_stage, input bit poke);
        int s = 0, rd_i = 0, wr_i = 0, dn = 0, last_re = 0, after = 0, t;
        int rdq[$];
        bit fin = 0;
        logic [5:0] ea;
        for (int k = 0; k < 2000 && !fin; k++) begin
            @(negedge clk);
            start = (poke && k == 200);
            if (re === 1'b1) begin
                ea = 6'((exp_off(s) + rd_i) % MH);
                if (rd_i == 0 && s > 0) begin
                    vectors++;
                    if (cyc - last_re !== PL + 1) begin
                        errors++;
                        $display("FAIL read_gap stage=%0d got %0d want %0d", s, cyc - last_re, PL + 1);
                    end
                end
                vectors++;
                if (addr_read !== {4{ea}}) begin
                    errors++;
                    $display("FAIL read_addr stage=%0d cnt=%0d got %h want %0d", s, rd_i, addr_read, ea);
                end
                if (s == 3 && rd_i == 20) begin
                    vectors++;
                    if (addr_read[5:0] !== 6'd4) begin
                        errors++;
                        $display("FAIL stage3_addr got %0d want 4", addr_read[5:0]);
                    end
                end
                vectors++;
                if (tw_addr !== 6'(rd_i) || stage !== 4'(s)) begin
                    errors++;
                    $display("FAIL read_tw_stage got tw=%0d stage=%0d want tw=%0d stage=%0d", tw_addr, stage, rd_i, s);
                end
                vectors++;
                if (bypass_en !== 1'(s < 4)) begin
                    errors++;
                    $display("FAIL bypass stage=%0d got %b want %b", s, bypass_en, s < 4);
                end
                vectors++;
                if ({m0, m11, m12, m13, m14, m21, m22, m23, m24} !== 11'b1_0_01_01_1_0_0_1_1) begin
                    errors++;
                    $display("FAIL mux_sel got %b want 10010110011", {m0, m11, m12, m13, m14, m21, m22, m23, m24});
                end
                rdq.push_back(cyc);
                last_re = cyc;
                rd_i++;
                if (rd_i == MH) begin rd_i = 0; s++; end
            end
            if (we === 1'b1) begin
                vectors++;
                if (rdq.size() == 0) begin
                    errors++;
                    $display("FAIL wb_spurious got we=1 want 0 at cycle %0d", cyc);
                end else begin
                    t = rdq.pop_front();
                    if (cyc - t !== PL || addr_write !== {4{6'(wr_i)}}) begin
                        errors++;
                        $display("FAIL wb got lat=%0d addr=%h want lat=%0d addr=%0d", cyc - t, addr_write, PL, wr_i);
                    end
                end
                wr_i = (wr_i + 1) % MH;
            end
            vectors++;
            if (sif.s_ready !== 1'b0) begin
                errors++;
                $display("FAIL compute_ready got %b want 0", sif.s_ready);
            end
            if (done === 1'b1) begin
                dn++;
                vectors++;
                if (cyc - t_acc !== DONE_AT + stalls) begin
                    errors++;
                    $display("FAIL done_time got %0d want %0d", cyc - t_acc, DONE_AT + stalls);
                end
            end
            if (stop_stage < NS && s == stop_stage && rd_i == 8) fin = 1;
            if (dn > 0) begin
                after++;
                if (after == 4) fin = 1;
            end
        end
        start = 1'b0;
        vectors++;
        if (!fin) begin
            errors++;
            $display("FAIL compute_timeout got stage=%0d done=%0d want completion", s, dn);
        end
        if (stop_stage >= NS) begin
            vectors++;
            if (dn !== 1 || s !== NS || rdq.size() !== 0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL run_end got done=%0d passes=%0d pending=%0d busy=%b want 1 %0d 0 0",
                         dn, s, rdq.size(), busy, NS);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sif.s_valid = 1'b0; sif.s_data = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if (any_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got nonzero want all 0");
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (any_out !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs got nonzero want all 0");
        end
    endtask

    task automatic test_load_stall();
        int t;
        do_load(1'b1, 10, 5, t);
        run_compute(t, 5, NS, 1'b1);
    endtask

    task automatic test_back_to_back();
        int t;
        for (int n = 0; n < 2; n++) begin
            do_load(1'b0, -1, 0, t);
            run_compute(t, 0, NS, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        do_load(1'b0, -1, 0, t);
        run_compute(t, 0, 5, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (any_out !== 1'b0 || we !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got we=%b busy=%b any=%b want 0 0 0", we, busy, any_out);
        end
        rst = 1'b0;
        for (int k = 0; k < PL + 3; k++) begin
            @(negedge clk);
            vectors++;
            if (we !== 1'b0 || re !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset got we=%b re=%b busy=%b want 0 0 0", we, re, busy);
            end
        end
        do_load(1'b0, -1, 0, t);
        run_compute(t, 0, NS, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load_stall();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no completion want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rfft_seq.md
RFFT_SEQ -- requirements
Module: rfft_seq

Interface
REQ-001 SHALL have parameters: DATA_BIT, 16, sample width; ADDR_BIT, 6, bank address width; N, 256, FFT length; MEM_HEIGHT, N/4, rows per bank; NUM_STAGES, 8, compute passes; PIPE_LAT, 2, butterfly read-to-write latency in cycles.
REQ-002 SHALL use reset rst, synchronous, active-high; clock clk.
REQ-003 SHALL have ports:
  clk  in  1  clock;
  rst  in  1  sync reset;
  start  in  1  begin load+compute;
  s_valid  in  1  input row valid;
  s_ready  out  1  input row accepted;
  s_data  in  4*DATA_BIT  four samples {x[3*MH+r],x[2*MH+r],x[MH+r],x[r]};
  in0..in3  out  DATA_BIT each  bank write data;
  en, re, we  out  1 each  memory enable/read/write;
  addr_read  out  4*ADDR_BIT  per-bank read address;
  addr_write  out  4*ADDR_BIT  per-bank write address;
  m0, m11, m14, m21, m22, m23, m24  out  1 each  datapath mux selects;
  m12, m13  out  2 each  datapath mux selects;
  bypass_en  out  1  twiddle bypass;
  tw_addr  out  ADDR_BIT  twiddle ROM index;
  stage  out  4  current pass;
  busy  out  1  not IDLE;
  done  out  1  one-cycle completion pulse.

Function
REQ-004 SHALL implement FSM IDLE -> LOAD -> READ -> WAIT -> (READ | FIN) -> IDLE.
REQ-005 IDLE: start=1 -> LOAD, row counter cnt=0; start while busy SHALL be ignored.
REQ-006 LOAD: s_ready=1, m0=0; on s_valid&s_ready: we=1, en=1, in0..in3 = s_data lanes 0..3, all four addr_write lanes = cnt, cnt++; after beat MEM_HEIGHT-1 -> READ, stage=0, cnt=0.
REQ-007 LOAD with s_valid=0 SHALL stall (we=0, cnt held), with no timeout.
REQ-008 READ: m0=1, en=1, re=1; all addr_read lanes = (off(stage)+cnt) mod MEM_HEIGHT, with off=0 for stage 0,1 and off=MEM_HEIGHT-(MEM_HEIGHT>>(stage-1)) for stage>=2; tw_addr=cnt; cnt++; after cnt=MEM_HEIGHT-1 -> WAIT.
REQ-009 Write-back: we=1 and all addr_write lanes = cnt delayed exactly PIPE_LAT cycles, asserted for exactly MEM_HEIGHT cycles per stage, starting PIPE_LAT cycles after the first READ cycle.
REQ-010 WAIT: re=0 for PIPE_LAT cycles until the last write completes; then stage++, cnt=0 -> READ, or -> FIN if stage=NUM_STAGES-1.
REQ-011 bypass_en=1 for stage 0..3, 0 otherwise; m11=0, m12=1, m13=1, m14=1, m21=0, m22=0, m23=1, m24=1 in READ/WAIT.
REQ-012 FIN: done=1 for one cycle -> IDLE; busy=1 in all states except IDLE.
REQ-013 Address arithmetic SHALL be modulo MEM_HEIGHT (ADDR_BIT wrap); cnt SHALL never exceed MEM_HEIGHT-1.
REQ-014 Outside write cycles in0..in3 SHALL hold their last value; outside READ re=0.

Reset
REQ-015 rst SHALL force IDLE, cnt=0, stage=0, delay line cleared, and all outputs 0 (s_ready, en, re, we, busy, done, addr_*, in0..in3, mux selects, bypass_en, tw_addr) in the next cycle, including mid-LOAD or mid-compute; no pending write SHALL issue after rst.

Structure
REQ-016 A package rfft_pkg SHALL hold DATA_BIT, ADDR_BIT, N, MEM_HEIGHT, NUM_STAGES, PIPE_LAT, the FSM state enum, and the constant mux-select values.
REQ-017 The PIPE_LAT address/we delay line SHALL be sub-module rfft_delay (parameterised depth and width).

Verification
REQ-018 Reset: rst=1 for 2 cycles -> all outputs 0, busy=0.
REQ-019 Load: start, then 64 rows with s_data lane k = k*64+r -> we on 64 cycles, addr_write=r, in2=128+r; enters READ at stage 0.
REQ-020 Stall: s_valid low for 5 cycles at row 10 -> cnt holds 10, no write; loading resumes at row 10.
REQ-021 Stage 3 address: cnt=20 -> addr_read lanes=(48+20) mod 64=4; bypass_en=1; stage 4 -> bypass_en=0.
REQ-022 Full run: done exactly once, at 64 + 8*(64+PIPE_LAT) + 1 cycles after first accepted row (no stalls); start during busy ignored.
REQ-023 Reset mid-stage 5 -> next cycle IDLE, we=0; a fresh start completes normally.
